// File: rtl/constraint_stim_gen.sv
// constraint_stim_gen: LFSR-filled candidate generator with checker retry,
// deterministic fallback repair and a valid/ready output stream.
module constraint_stim_gen #(
  parameter int VEC_W = 307,
  parameter int MAX_TRIES = 64,
  parameter int FIX_LSB = 230,
  parameter int FIX_W = 4,
  parameter logic [FIX_W-1:0] FIX_VAL = 4'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic [VEC_W-1:0] cand_data,
  input  logic             cand_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic             out_fixed,
  output logic             busy,
  output logic [15:0]      cnt_accept,
  output logic [15:0]      cnt_reject
);

  localparam int NW = (VEC_W + 31) / 32;
  localparam int CW = NW * 32;
  localparam int FCW = $clog2(NW + 1);
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [FCW-1:0] FILL_LAST = FCW'(NW - 1);
  localparam logic [15:0] TRY_MAX = 16'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CHECK,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nxt;
  logic [CW-1:0]    cand_reg;
  logic [FCW-1:0]   fill_cnt;
  logic [15:0]      tries;
  logic [15:0]      tries_inc;
  logic [VEC_W-1:0] fixed_vec;
  logic             fill_last;
  logic             try_hit;
  logic             do_fill;
  logic             do_check;
  logic             do_xfer;

  assign lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);
  assign cand_data = cand_reg[VEC_W-1:0];
  assign fill_last = (fill_cnt == FILL_LAST);
  assign tries_inc = tries + 16'd1;
  assign try_hit   = (tries_inc == TRY_MAX);

  if (CW > VEC_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^cand_reg[CW-1:VEC_W];
  end

  // Repaired vector: current candidate with the forced field overwritten
  always_comb begin
    fixed_vec = cand_data;
    fixed_vec[FIX_LSB +: FIX_W] = FIX_VAL;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a seed load aborts whatever is in flight
  always_comb begin
    state_nxt = state;
    if (seed_load) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (en) state_nxt = FILL;
        FILL:  if (fill_last) state_nxt = CHECK;
        CHECK: state_nxt = (cand_sat || try_hit) ? HOLD : FILL;
        HOLD:  if (out_ready) state_nxt = en ? FILL : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state control strobes
  always_comb begin
    busy     = (state != IDLE);
    do_fill  = (state == FILL);
    do_check = (state == CHECK);
    do_xfer  = (state == HOLD) && out_ready;
  end

  // Candidate fill, check outcome and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= 32'h1;
      cand_reg  <= '0;
      fill_cnt  <= '0;
      tries     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_fixed <= 1'b0;
    end else if (seed_load) begin
      lfsr      <= (seed == 32'h0) ? 32'h1 : seed;
      fill_cnt  <= '0;
      tries     <= '0;
      out_valid <= 1'b0;
      out_fixed <= 1'b0;
    end else begin
      if (do_fill) begin
        lfsr     <= lfsr_nxt;
        cand_reg <= {lfsr_nxt, cand_reg[CW-1:32]};
        fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
      end
      if (do_check) begin
        if (cand_sat) begin
          out_data  <= cand_data;
          out_fixed <= 1'b0;
          out_valid <= 1'b1;
          tries     <= '0;
        end else if (try_hit) begin
          out_data  <= fixed_vec;
          out_fixed <= 1'b1;
          out_valid <= 1'b1;
          tries     <= '0;
        end else begin
          tries <= tries_inc;
        end
      end
      if (do_xfer) begin
        out_valid <= 1'b0;
        out_fixed <= 1'b0;
      end
    end
  end

  // Saturating accept / reject counters, kept across seed loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_accept <= '0;
      cnt_reject <= '0;
    end else if (!seed_load) begin
      if (do_check && !cand_sat && cnt_reject != 16'hFFFF)
        cnt_reject <= cnt_reject + 16'd1;
      if (do_xfer && cnt_accept != 16'hFFFF)
        cnt_accept <= cnt_accept + 16'd1;
    end
  end

endmodule

// File: tb/tb_constraint_stim_gen.sv
// tb_constraint_stim_gen: table vectors, directed corner sequences and
// randomized checker predicates against a word-level LFSR model.
module tb_constraint_stim_gen;

  localparam int VEC_W = 307;
  localparam int MT = 3;
  localparam int NW = 10;
  localparam int FIX_LSB = 230;

  typedef logic [VEC_W-1:0] v_t;

  typedef struct {
    logic [31:0] seed;
    int          mode;
    int          lat;
    logic        fx;
    int          rej;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [31:0] seed;
  v_t          cand_data;
  logic        cand_sat;
  logic        out_valid;
  logic        out_ready;
  v_t          out_data;
  logic        out_fixed;
  logic        busy;
  logic [15:0] cnt_accept;
  logic [15:0] cnt_reject;

  constraint_stim_gen #(.MAX_TRIES(MT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .seed_load(seed_load),
    .seed(seed),
    .cand_data(cand_data),
    .cand_sat(cand_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_fixed(out_fixed),
    .busy(busy),
    .cnt_accept(cnt_accept),
    .cnt_reject(cnt_reject)
  );

  always #5 clk = ~clk;

  int s_mode;
  v_t s_target;
  v_t s_mask;

  function automatic logic pred(input v_t v, input int mode,
                                input v_t tgt, input v_t msk);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return v == tgt;
      default: return ^(v & msk);
    endcase
  endfunction

  always_comb cand_sat = pred(cand_data, s_mode, s_target, s_mask);

  logic [31:0] m_lfsr;
  int exp_acc;
  int exp_rej;
  v_t last_d;
  logic last_fx;
  int n_cmp;
  int n_bad;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic next_cand(output v_t c);
    logic [NW*32-1:0] w;
    w = '0;
    for (int i = 0; i < NW; i++) begin
      m_lfsr = step(m_lfsr);
      w[32*i +: 32] = m_lfsr;
    end
    c = w[VEC_W-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input v_t act, input v_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " out_valid"}, v_t'(out_valid), '0);
    chk({nm, " out_fixed"}, v_t'(out_fixed), '0);
    chk({nm, " busy"}, v_t'(busy), '0);
    chk({nm, " cnt_accept"}, v_t'(cnt_accept), '0);
    chk({nm, " cnt_reject"}, v_t'(cnt_reject), '0);
    chk({nm, " out_data"}, out_data, '0);
    chk({nm, " cand_data"}, cand_data, '0);
  endtask

  task automatic do_seed(input logic [31:0] s);
    seed = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_lfsr = (s == 32'h0) ? 32'h1 : s;
  endtask

  // Predict the next output from the model, then wait for it.
  task automatic wait_out(input int lat0, output int lat);
    v_t c;
    int tries;
    logic fx;
    fx = 1'b0;
    tries = 0;
    c = '0;
    for (int t = 1; t <= MT; t++) begin
      next_cand(c);
      tries = t;
      if (pred(c, s_mode, s_target, s_mask)) break;
      if (t == MT) begin
        c[FIX_LSB +: 4] = 4'h1;
        fx = 1'b1;
      end
    end
    exp_rej += fx ? tries : tries - 1;
    last_d = c;
    last_fx = fx;
    lat = lat0;
    while (out_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk("latency", v_t'(lat), v_t'(11 * tries + 1));
    chk("out_data", out_data, last_d);
    chk("out_fixed", v_t'(out_fixed), v_t'(last_fx));
    chk("cnt_reject", v_t'(cnt_reject), v_t'(exp_rej));
    chk("busy hold", v_t'(busy), v_t'(1));
  endtask

  task automatic xfer(input int stall);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall valid", v_t'(out_valid), v_t'(1));
      chk("stall data", out_data, last_d);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_acc++;
    chk("cnt_accept", v_t'(cnt_accept), v_t'(exp_acc));
    chk("valid drop", v_t'(out_valid), '0);
    chk("fixed drop", v_t'(out_fixed), '0);
    chk("busy after xfer", v_t'(busy), v_t'(en));
  endtask

  rec_t tbl[4];

  initial begin
    int lat;
    int lat0;
    int r0;
    v_t c;
    logic [31:0] sv;
    logic [NW*32-1:0] wide;

    tbl[0] = '{32'h0000_0000, 0, 12, 1'b0, 0};
    tbl[1] = '{32'hDEAD_BEEF, 2, 34, 1'b0, 2};
    tbl[2] = '{32'h1234_5678, 1, 34, 1'b1, 3};
    tbl[3] = '{32'hFFFF_FFFF, 0, 12, 1'b0, 0};

    n_cmp = 0;
    n_bad = 0;
    exp_acc = 0;
    exp_rej = 0;
    m_lfsr = 32'h1;
    rst_n = 1'b0;
    en = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    out_ready = 1'b0;
    s_mode = 0;
    s_target = '0;
    s_mask = '0;
    last_d = '0;
    last_fx = 1'b0;

    #12;
    chk_reset("reset");
    #1 rst_n = 1'b1;
    tick();
    chk_reset("post reset");

    // Table: seed, checker policy, expected latency / fixed / rejects
    for (int i = 0; i < 4; i++) begin
      s_mode = tbl[i].mode;
      en = 1'b1;
      do_seed(tbl[i].seed);
      chk("seed idle", v_t'(busy), '0);
      if (s_mode == 2) begin
        sv = m_lfsr;
        for (int k = 0; k < 3; k++) next_cand(c);
        s_target = c;
        m_lfsr = sv;
      end
      r0 = exp_rej;
      wait_out(0, lat);
      chk("tbl lat", v_t'(lat), v_t'(tbl[i].lat));
      chk("tbl fixed", v_t'(out_fixed), v_t'(tbl[i].fx));
      chk("tbl rej", v_t'(cnt_reject), v_t'(r0 + tbl[i].rej));
      if (tbl[i].fx) chk("fix field", v_t'(out_data[233:230]), v_t'(4'h1));
      xfer(0);
    end

    // Backpressure for 20 cycles, then FILL resumes at once
    s_mode = 0;
    do_seed(32'hA5A5_0F0F);
    wait_out(0, lat);
    xfer(20);

    // Seed load in the middle of FILL
    repeat (4) tick();
    chk("busy in fill", v_t'(busy), v_t'(1));
    do_seed(32'h0BAD_F00D);
    chk("fill abort busy", v_t'(busy), '0);
    chk("fill abort valid", v_t'(out_valid), '0);
    wait_out(0, lat);
    xfer(1);

    // Seed load while a repaired vector is held
    s_mode = 1;
    wait_out(1, lat);
    do_seed(32'h0000_0077);
    chk("hold abort valid", v_t'(out_valid), '0);
    chk("hold abort fixed", v_t'(out_fixed), '0);
    chk("hold abort busy", v_t'(busy), '0);
    chk("hold abort acc", v_t'(cnt_accept), v_t'(exp_acc));
    s_mode = 0;
    wait_out(0, lat);
    xfer(0);

    // Randomized checker predicates, stalls, en drops and reseeds
    s_mode = 3;
    lat0 = 1;
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NW; k++) wide[32*k +: 32] = $urandom;
      s_mask = wide[VEC_W-1:0];
      if (!en) begin
        en = 1'b1;
        lat0 = 0;
      end
      if ($urandom_range(0, 4) == 0) begin
        do_seed($urandom);
        lat0 = 0;
      end
      wait_out(lat0, lat);
      en = ($urandom_range(0, 3) != 0);
      xfer($urandom_range(0, 3));
      lat0 = 1;
    end

    // Asynchronous reset while a vector is valid
    en = 1'b1;
    s_mode = 0;
    wait_out(lat0, lat);
    #3 rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    #2 rst_n = 1'b1;
    m_lfsr = 32'h1;
    exp_acc = 0;
    exp_rej = 0;
    wait_out(0, lat);
    xfer(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/constraint_stim_gen.md
Name: constraint_stim_gen

Overview:
- Sequential stimulus generator that drives the 50-variable packed candidate vector into a combinational constraint checker and reads its single satisfied bit back.
- Fills candidates from a 32-bit LFSR, retries until the checker accepts, then emits accepted vectors over a valid/ready stream to the solver testbench.
- After MAX_TRIES consecutive rejections it emits a deterministic repaired vector, so the stream never stalls forever.

Parameters:
- VEC_W, 307, packed candidate width; var_0 at bit 0, var_49 at the MSBs, fields in index order.
- MAX_TRIES, 64, consecutive rejections allowed before fallback; range 1..65535.
- FIX_LSB, 230, LSB of the field forced on fallback (var_38).
- FIX_W, 4, width of the forced field.
- FIX_VAL, 4'h1, value written into the forced field on fallback.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request; sampled only in IDLE and on an output transfer
- seed_load  in  1  one-cycle pulse; loads the LFSR and aborts the current operation
- seed  in  32  seed value; 0 is replaced by 32'h1
- cand_data  out  VEC_W  candidate driven to the checker
- cand_sat  in  1  checker result for cand_data, combinational, sampled in CHECK
- out_valid  out  1  an accepted vector is available
- out_ready  in  1  consumer accepts the vector
- out_data  out  VEC_W  accepted vector
- out_fixed  out  1  out_data came from the fallback repair
- busy  out  1  state is not IDLE
- cnt_accept  out  16  vectors transferred, saturating
- cnt_reject  out  16  rejected candidates, saturating

Behaviour:
- Reset values: LFSR = 32'h1, cand_reg = 0, out_data = 0, and out_valid, out_fixed, busy, cnt_accept, cnt_reject, tries all 0. State = IDLE.
- LFSR: Galois, right shift, one step per FILL cycle. next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- NW = ceil(VEC_W/32), which is 10 by default. cand_reg is NW*32 bits wide.
- Each FILL cycle: cand_reg <= {lfsr_next, cand_reg[NW*32-1:32]}. cand_data = cand_reg[VEC_W-1:0].
- IDLE: if en = 1, go to FILL and set fill_cnt = 0.
- FILL: runs exactly NW cycles, then goes to CHECK. A change on en has no effect here.
- CHECK: one cycle; samples cand_sat.
  - cand_sat = 1: out_data <= cand_data, out_fixed <= 0, out_valid <= 1, tries <= 0, go to HOLD.
  - cand_sat = 0: cnt_reject++ and tries++.
  - If the new tries == MAX_TRIES: out_data <= cand_data with bits [FIX_LSB+FIX_W-1:FIX_LSB] = FIX_VAL, out_fixed <= 1, out_valid <= 1, tries <= 0, go to HOLD.
  - Otherwise go back to FILL for a fresh candidate.
- HOLD: out_valid, out_data and out_fixed are held stable while out_ready = 0.
  - On out_valid & out_ready: cnt_accept++, out_valid <= 0, out_fixed <= 0.
  - Then go to FILL if en = 1, else to IDLE.
- Latency: en sampled in IDLE at cycle 0 → FILL in cycles 1..NW → CHECK in cycle NW+1 → out_valid high from cycle NW+2 (cycle 12 by default). A transfer followed by an immediate accept gives one vector per NW+2 cycles.
- seed_load has priority over all state logic in every state:
  - LFSR <= (seed == 0) ? 32'h1 : seed.
  - out_valid, out_fixed and tries are cleared; state goes to IDLE.
  - cand_reg and the counters are kept.
  - A vector pending in HOLD is discarded and not counted.
- Counters saturate at 16'hFFFF and never wrap.
- An asynchronous reset asserted mid-operation returns every register to its reset value immediately.
- busy = (state != IDLE).

Test Plan:
- Reset, then seed_load with seed = 0, en = 1, cand_sat tied to 1:
  - out_valid rises exactly 12 cycles after en is sampled.
  - out_data equals the 10 LFSR words after start state 32'h1, per the reference model.
  - out_fixed = 0.
- cand_sat = 0 for the first 2 CHECKs, then 1:
  - cnt_reject = 2, cnt_accept = 1 after the transfer.
  - out_valid rises at cycle 3*11+1 = 34.
- MAX_TRIES = 3, cand_sat tied to 0:
  - After the 3rd CHECK, out_valid = 1 and out_fixed = 1.
  - out_data[233:230] = 4'h1; all other bits equal the 3rd candidate.
  - cnt_reject = 3.
- Backpressure: out_ready = 0 for 20 cycles, then 1:
  - out_data and out_valid stay stable throughout.
  - A single transfer occurs and cnt_accept increments by 1.
  - With en still 1, FILL restarts on the next cycle.
- seed_load during FILL cycle 5, and separately during HOLD:
  - State returns to IDLE and out_valid = 0.
  - With en = 1, the next output reproduces the vector expected from the new seed.
- rst_n pulled low while out_valid = 1:
  - All outputs drop to reset values asynchronously, before the next clock edge.
